// File: rtl/sorter_pkg.sv
// Shared element type, key/tag ordering and constant helpers for the bitonic sorter.
package sorter_pkg;

    localparam int SIZE        = 16;
    localparam int DATA_WIDTH  = 8;
    localparam int INDEX_WIDTH = $clog2(SIZE);

    typedef struct packed {
        logic [INDEX_WIDTH-1:0] idx;
        logic [DATA_WIDTH-1:0]  key;
    } elem_t;

    // Key is the major field and the tag breaks ties, so the order is total.
    function automatic logic elem_gt(input elem_t a, input elem_t b);
        return {a.key, a.idx} > {b.key, b.idx};
    endfunction

    // A flat stage number s maps to (level, step): level L contributes L merge steps.
    function automatic int stage_level(input int s);
        int lvl;
        int base;
        lvl  = 1;
        base = 0;
        while (s >= base + lvl) begin
            base += lvl;
            lvl++;
        end
        return lvl;
    endfunction

    function automatic int stage_step(input int s);
        int lvl;
        int base;
        lvl  = 1;
        base = 0;
        while (s >= base + lvl) begin
            base += lvl;
            lvl++;
        end
        return s - base;
    endfunction

endpackage

// File: rtl/comparison_size_sorter_cmp_swap.sv
// Combinational compare-exchange of one {key, tag} pair; x receives the element that
// belongs first in the requested direction (smaller when dir_up=1).
module bitonic_cmp_swap #(
    parameter int DATA_WIDTH  = 8,
    parameter int INDEX_WIDTH = 4
) (
    input  logic                   dir_up,
    input  logic [DATA_WIDTH-1:0]  a_key,
    input  logic [INDEX_WIDTH-1:0] a_idx,
    input  logic [DATA_WIDTH-1:0]  b_key,
    input  logic [INDEX_WIDTH-1:0] b_idx,
    output logic [DATA_WIDTH-1:0]  x_key,
    output logic [INDEX_WIDTH-1:0] x_idx,
    output logic [DATA_WIDTH-1:0]  y_key,
    output logic [INDEX_WIDTH-1:0] y_idx
);
    import sorter_pkg::*;

    logic a_gt_b;
    logic swap;

    generate
        if (DATA_WIDTH == sorter_pkg::DATA_WIDTH && INDEX_WIDTH == sorter_pkg::INDEX_WIDTH) begin : g_pkg_cmp
            elem_t ea;
            elem_t eb;
            assign ea     = {a_idx, a_key};
            assign eb     = {b_idx, b_key};
            assign a_gt_b = elem_gt(ea, eb);
        end else begin : g_wide_cmp
            assign a_gt_b = {a_key, a_idx} > {b_key, b_idx};
        end
    endgenerate

    // Equal composites are identical, so swapping them in the descending case is harmless.
    assign swap  = a_gt_b ^ ~dir_up;

    assign x_key = swap ? b_key : a_key;
    assign x_idx = swap ? b_idx : a_idx;
    assign y_key = swap ? a_key : b_key;
    assign y_idx = swap ? a_idx : b_idx;

endmodule

// File: rtl/comparison_size_sorter.sv
// Bitonic sorting network over SIZE {key, tag} pairs with a single registered output stage.
module comparison_size_sorter #(
    parameter int   SIZE        = 16,
    parameter int   DEPTH       = $clog2(SIZE),
    parameter logic ASCENDING   = 1'b1,
    parameter int   DATA_WIDTH  = 8,
    parameter int   INDEX_WIDTH = $clog2(SIZE)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 in_valid,
    input  logic [SIZE-1:0][DATA_WIDTH-1:0]      data_in,
    input  logic [SIZE-1:0][INDEX_WIDTH-1:0]     index_in,
    output logic [SIZE*DATA_WIDTH-1:0]           data_out,
    output logic [SIZE*INDEX_WIDTH-1:0]          index_out,
    output logic                                 out_valid
);
    import sorter_pkg::*;

    localparam int NSTAGES = DEPTH * (DEPTH + 1) / 2;

    generate
        if (SIZE < 2 || (SIZE & (SIZE - 1)) != 0 || DEPTH != $clog2(SIZE)) begin : g_bad_cfg
            $error("comparison_size_sorter: SIZE must be a power of two >= 2 and DEPTH = log2(SIZE)");
        end
    endgenerate

    logic [DATA_WIDTH-1:0]      key_s [0:NSTAGES][0:SIZE-1];
    logic [INDEX_WIDTH-1:0]     idx_s [0:NSTAGES][0:SIZE-1];
    logic [SIZE*DATA_WIDTH-1:0]  key_flat;
    logic [SIZE*INDEX_WIDTH-1:0] idx_flat;

    genvar s, i;
    generate
        for (i = 0; i < SIZE; i++) begin : g_in
            assign key_s[0][i] = data_in[i];
            assign idx_s[0][i] = index_in[i];
            assign key_flat[i*DATA_WIDTH +: DATA_WIDTH]   = key_s[NSTAGES][i];
            assign idx_flat[i*INDEX_WIDTH +: INDEX_WIDTH] = idx_s[NSTAGES][i];
        end

        // Level LVL merges bitonic runs of length K; step STEP compares elements J apart.
        for (s = 0; s < NSTAGES; s++) begin : g_stage
            localparam int LVL  = stage_level(s);
            localparam int STEP = stage_step(s);
            localparam int K    = 1 << LVL;
            localparam int J    = 1 << (LVL - 1 - STEP);
            for (i = 0; i < SIZE; i++) begin : g_elem
                if ((i & J) == 0) begin : g_ce
                    localparam logic UP = ((i & K) == 0) ? ASCENDING : ~ASCENDING;
                    bitonic_cmp_swap #(
                        .DATA_WIDTH  (DATA_WIDTH),
                        .INDEX_WIDTH (INDEX_WIDTH)
                    ) u_ce (
                        .dir_up (UP),
                        .a_key  (key_s[s][i]),
                        .a_idx  (idx_s[s][i]),
                        .b_key  (key_s[s][i+J]),
                        .b_idx  (idx_s[s][i+J]),
                        .x_key  (key_s[s+1][i]),
                        .x_idx  (idx_s[s+1][i]),
                        .y_key  (key_s[s+1][i+J]),
                        .y_idx  (idx_s[s+1][i+J])
                    );
                end
            end
        end
    endgenerate

    // Output register: result of the combinational network lands here one edge later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out  <= '0;
            index_out <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                data_out  <= key_flat;
                index_out <= idx_flat;
            end
        end
    end

endmodule

// File: tb/tb_comparison_size_sorter.sv
// Directed and randomised checks of comparison_size_sorter at SIZE=8 (both orders) and SIZE=16.
module tb_comparison_size_sorter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic             v8 = 1'b0;
    logic [7:0][7:0]  d8 = '0;
    logic [7:0][2:0]  i8 = '0;
    logic [63:0]      do8a, do8d;
    logic [23:0]      io8a, io8d;
    logic             ov8a, ov8d;

    logic             v16 = 1'b0;
    logic [15:0][7:0] d16 = '0;
    logic [15:0][3:0] i16 = '0;
    logic [127:0]     do16;
    logic [63:0]      io16;
    logic             ov16;

    int nvec = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    comparison_size_sorter #(.SIZE(8), .ASCENDING(1'b1)) u8a (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .data_in(d8), .index_in(i8),
        .data_out(do8a), .index_out(io8a), .out_valid(ov8a));

    comparison_size_sorter #(.SIZE(8), .ASCENDING(1'b0)) u8d (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .data_in(d8), .index_in(i8),
        .data_out(do8d), .index_out(io8d), .out_valid(ov8d));

    comparison_size_sorter #(.SIZE(16), .ASCENDING(1'b1)) u16 (
        .clk(clk), .rst_n(rst_n), .in_valid(v16), .data_in(d16), .index_in(i16),
        .data_out(do16), .index_out(io16), .out_valid(ov16));

    function automatic logic [63:0] flat_k8(input int v[8]);
        logic [63:0] r;
        for (int k = 0; k < 8; k++) r[k*8 +: 8] = 8'(v[k]);
        return r;
    endfunction

    function automatic logic [23:0] flat_t8(input int v[8]);
        logic [23:0] r;
        for (int k = 0; k < 8; k++) r[k*3 +: 3] = 3'(v[k]);
        return r;
    endfunction

    task automatic drive8(input int k[8], input int t[8]);
        for (int n = 0; n < 8; n++) begin
            d8[n] = 8'(k[n]);
            i8[n] = 3'(t[n]);
        end
        v8 = 1'b1;
    endtask

    task automatic test_reset();
        int k[8];
        int t[8];
        int ek[8];
        int et[8];
        k  = '{5, 3, 7, 0, 255, 1, 128, 2};
        t  = '{0, 1, 2, 3, 4, 5, 6, 7};
        ek = '{0, 1, 2, 3, 5, 7, 128, 255};
        et = '{3, 5, 7, 1, 0, 2, 6, 4};
        rst_n = 1'b0;
        drive8(k, t);
        v16 = 1'b1;
        d16 = {16{8'hA5}};
        repeat (2) @(posedge clk);
        #1;
        nvec++; if (ov8a !== 1'b0) begin nfail++; $display("FAIL reset_valid got %b want 0", ov8a); end
        nvec++; if (do8a !== 64'd0) begin nfail++; $display("FAIL reset_data got %h want 0", do8a); end
        nvec++; if (io8a !== 24'd0) begin nfail++; $display("FAIL reset_index got %h want 0", io8a); end
        nvec++; if (ov16 !== 1'b0 || do16 !== 128'd0 || io16 !== 64'd0) begin
            nfail++; $display("FAIL reset_16 got v=%b d=%h i=%h want zeros", ov16, do16, io16);
        end
        v16 = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        nvec++; if (ov8a !== 1'b1) begin nfail++; $display("FAIL release_valid got %b want 1", ov8a); end
        nvec++; if (do8a !== flat_k8(ek) || io8a !== flat_t8(et)) begin
            nfail++; $display("FAIL release_first got %h/%h want %h/%h", do8a, io8a, flat_k8(ek), flat_t8(et));
        end
    endtask

    task automatic test_sort_dirs();
        int k[8];
        int t[8];
        int eka[8];
        int eta[8];
        int ekd[8];
        int etd[8];
        k   = '{5, 3, 7, 0, 255, 1, 128, 2};
        t   = '{0, 1, 2, 3, 4, 5, 6, 7};
        eka = '{0, 1, 2, 3, 5, 7, 128, 255};
        eta = '{3, 5, 7, 1, 0, 2, 6, 4};
        ekd = '{255, 128, 7, 5, 3, 2, 1, 0};
        etd = '{4, 6, 2, 0, 1, 7, 5, 3};
        drive8(k, t);
        @(posedge clk);
        #1;
        nvec++; if (do8a !== flat_k8(eka)) begin nfail++; $display("FAIL asc_keys got %h want %h", do8a, flat_k8(eka)); end
        nvec++; if (io8a !== flat_t8(eta)) begin nfail++; $display("FAIL asc_tags got %h want %h", io8a, flat_t8(eta)); end
        nvec++; if (do8d !== flat_k8(ekd)) begin nfail++; $display("FAIL desc_keys got %h want %h", do8d, flat_k8(ekd)); end
        nvec++; if (io8d !== flat_t8(etd)) begin nfail++; $display("FAIL desc_tags got %h want %h", io8d, flat_t8(etd)); end
        nvec++; if (ov8d !== 1'b1) begin nfail++; $display("FAIL desc_valid got %b want 1", ov8d); end
    endtask

    task automatic test_ties();
        int k[8];
        int t[8];
        int tr[8];
        k  = '{66, 66, 66, 66, 66, 66, 66, 66};
        t  = '{0, 1, 2, 3, 4, 5, 6, 7};
        tr = '{7, 6, 5, 4, 3, 2, 1, 0};
        drive8(tr, t);
        drive8(k, tr);
        @(posedge clk);
        #1;
        nvec++; if (do8a !== {8{8'h42}}) begin nfail++; $display("FAIL ties_keys got %h want %h", do8a, {8{8'h42}}); end
        nvec++; if (io8a !== flat_t8(t)) begin nfail++; $display("FAIL ties_asc_tags got %h want %h", io8a, flat_t8(t)); end
        nvec++; if (io8d !== flat_t8(tr)) begin nfail++; $display("FAIL ties_desc_tags got %h want %h", io8d, flat_t8(tr)); end
    endtask

    task automatic test_back_to_back();
        int t[8];
        int k1[8];
        int k2[8];
        int e2t[8];
        int k3[8];
        int e3k[8];
        int e3t[8];
        t   = '{0, 1, 2, 3, 4, 5, 6, 7};
        k1  = '{10, 20, 30, 40, 50, 60, 70, 80};
        k2  = '{80, 70, 60, 50, 40, 30, 20, 10};
        e2t = '{7, 6, 5, 4, 3, 2, 1, 0};
        k3  = '{9, 200, 9, 33, 1, 250, 77, 0};
        e3k = '{0, 1, 9, 9, 33, 77, 200, 250};
        e3t = '{7, 4, 0, 2, 3, 6, 1, 5};
        drive8(k1, t);
        @(posedge clk);
        #1;
        nvec++; if (ov8a !== 1'b1 || do8a !== flat_k8(k1) || io8a !== flat_t8(t)) begin
            nfail++; $display("FAIL b2b_sorted got v=%b %h/%h want 1 %h/%h", ov8a, do8a, io8a, flat_k8(k1), flat_t8(t));
        end
        drive8(k2, t);
        @(posedge clk);
        #1;
        nvec++; if (ov8a !== 1'b1 || do8a !== flat_k8(k1) || io8a !== flat_t8(e2t)) begin
            nfail++; $display("FAIL b2b_reverse got v=%b %h/%h want 1 %h/%h", ov8a, do8a, io8a, flat_k8(k1), flat_t8(e2t));
        end
        drive8(k3, t);
        @(posedge clk);
        #1;
        nvec++; if (ov8a !== 1'b1 || do8a !== flat_k8(e3k) || io8a !== flat_t8(e3t)) begin
            nfail++; $display("FAIL b2b_random got v=%b %h/%h want 1 %h/%h", ov8a, do8a, io8a, flat_k8(e3k), flat_t8(e3t));
        end
        v8 = 1'b0;
        d8 = 'x;
        i8 = 'x;
        @(posedge clk);
        #1;
        nvec++; if (ov8a !== 1'b0) begin nfail++; $display("FAIL b2b_valid_drop got %b want 0", ov8a); end
        nvec++; if (do8a !== flat_k8(e3k) || io8a !== flat_t8(e3t)) begin
            nfail++; $display("FAIL b2b_hold got %h/%h want %h/%h", do8a, io8a, flat_k8(e3k), flat_t8(e3t));
        end
        @(posedge clk);
        #1;
        nvec++; if (ov8a !== 1'b0 || do8a !== flat_k8(e3k)) begin
            nfail++; $display("FAIL b2b_hold2 got v=%b %h want 0 %h", ov8a, do8a, flat_k8(e3k));
        end
    endtask

    task automatic test_random();
        logic [11:0]  c [16];
        logic [11:0]  tmp;
        logic [127:0] exp_d;
        logic [63:0]  exp_i;
        int           j;
        for (int p = 0; p < 1000; p++) begin
            for (int n = 0; n < 16; n++) begin
                d16[n] = 8'($urandom_range(0, (p % 2 == 1) ? 255 : 7));
                i16[n] = (p % 3 == 0) ? 4'($urandom_range(0, 15)) : 4'(n);
                c[n]   = {d16[n], i16[n]};
            end
            for (int a = 1; a < 16; a++) begin
                tmp = c[a];
                j = a - 1;
                while (j >= 0 && c[j] > tmp) begin
                    c[j+1] = c[j];
                    j--;
                end
                c[j+1] = tmp;
            end
            for (int n = 0; n < 16; n++) begin
                exp_d[n*8 +: 8] = c[n][11:4];
                exp_i[n*4 +: 4] = c[n][3:0];
            end
            v16 = 1'b1;
            @(posedge clk);
            #1;
            nvec++; if (ov16 !== 1'b1 || do16 !== exp_d || io16 !== exp_i) begin
                nfail++; $display("FAIL rand_%0d got v=%b %h/%h want 1 %h/%h", p, ov16, do16, io16, exp_d, exp_i);
            end
            if (p == 500) begin
                rst_n = 1'b0;
                #1;
                nvec++; if (ov16 !== 1'b0 || do16 !== 128'd0 || io16 !== 64'd0) begin
                    nfail++; $display("FAIL async_reset got v=%b %h/%h want zeros", ov16, do16, io16);
                end
                #1;
                rst_n = 1'b1;
            end
        end
        v16 = 1'b0;
        @(posedge clk);
        #1;
        nvec++; if (ov16 !== 1'b0) begin nfail++; $display("FAIL rand_valid_drop got %b want 0", ov16); end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_sort_dirs();
        test_ties();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/comparison_size_sorter.md
Name: comparison_size_sorter

Overview:
- Parameterised sorting network for a packet of SIZE byte-wide keys, each paired with an index tag.
- Outputs the keys in sorted order together with the permuted tags, so a downstream block knows each key's original position.
- Sits inside the transmitter sorter; its flattened outputs are concatenated with the preamble to form the sorted packet.
- Combinational bitonic network followed by one output register stage.

Parameters:
- SIZE, 16: number of elements; must be a power of two, at least 2.
- DEPTH, $clog2(SIZE): number of bitonic levels; must equal log2(SIZE), otherwise elaboration fails.
- ASCENDING, 1'b1: 1 puts the smallest key at element 0; 0 puts the largest key at element 0.
- DATA_WIDTH, 8: key width in bits.
- INDEX_WIDTH, $clog2(SIZE): tag width in bits.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  qualifies data_in/index_in this cycle.
- data_in  input  [SIZE-1:0][DATA_WIDTH-1:0]  keys; element i = data_in[i].
- index_in  input  [SIZE-1:0][INDEX_WIDTH-1:0]  tag of each element (normally i).
- data_out  output  SIZE*DATA_WIDTH  sorted keys; element k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- index_out  output  SIZE*INDEX_WIDTH  tags travelling with the keys; element k at bits [k*INDEX_WIDTH +: INDEX_WIDTH].
- out_valid  output  1  data_out/index_out hold a freshly sorted packet.

Behaviour:
- Single clock domain. Reset is asynchronous and active-low (rst_n).
- While rst_n=0, data_out, index_out and out_valid are all 0. Release takes effect on the next clk edge.
- Sort order is total: compare the concatenation {key, tag}. Equal keys are therefore ordered by tag in the same direction as the keys, and the output is deterministic.
- Network is a standard bitonic sort built from DEPTH levels:
  - Level L builds bitonic sequences of length 2^L and merges them with L compare-exchange stages.
  - Total compare-exchange stages: DEPTH*(DEPTH+1)/2, all combinational.
- Each compare-exchange swaps key and tag together, never separately.
- Latency is exactly 1 cycle:
  - On a clk edge with in_valid=1, the sorted result of that cycle's inputs is registered and out_valid=1 from that edge.
  - On an edge with in_valid=0, out_valid becomes 0 and data_out/index_out hold their previous values.
- Throughput is one packet per cycle; back-to-back valid cycles are sorted independently.
- Output is always a permutation of the input {key, tag} pairs. Duplicate keys and duplicate tags are preserved, never dropped.
- Reset asserted mid-stream clears the outputs immediately. The first valid cycle after release produces a correct result with no warm-up.
- X on inputs while in_valid=0 must not propagate to out_valid.

Decomposition:
- Shared package sorter_pkg holds:
  - DATA_WIDTH and the default SIZE;
  - an element typedef struct packed {logic [INDEX_WIDTH-1:0] idx; logic [DATA_WIDTH-1:0] key;};
  - a function elem_gt(a, b) implementing the {key, tag} comparison.
- One sub-module, bitonic_cmp_swap: a combinational compare-exchange of two elements with a direction input. It is instantiated from generate loops; the top module owns the output register and out_valid.

Test Plan:
- Reset: hold rst_n=0 while driving valid data -> data_out=0, index_out=0, out_valid=0. Release, then apply one valid cycle -> out_valid=1 one cycle later.
- SIZE=8, ASCENDING=1, keys {5,3,7,0,255,1,128,2}, tags 0..7 -> keys {0,1,2,3,5,7,128,255}, tags {3,5,7,1,0,2,6,4}, after 1 cycle.
- SIZE=8, ASCENDING=0, same keys and tags -> keys {255,128,7,5,3,2,1,0}, tags {4,6,2,0,1,7,5,3}.
- Ties, ASCENDING=1: all keys 0x42, tags 0..7 -> keys all 0x42, tags {0,1,...,7}.
- Back-to-back: three consecutive valid packets (one already sorted, one reverse sorted, one random), then in_valid=0:
  - each result appears exactly 1 cycle after its input;
  - out_valid drops on the cycle after the last valid input;
  - outputs hold their last values.
- Random: 1000 packets at SIZE=16 compared against a software sort on {key, tag} -> zero mismatches. Assert rst_n mid-run -> outputs clear asynchronously, before the next clk edge.
